fft_sdf_sequencer: RTL and testbench
====================================

Name: fft_sdf_sequencer

Overview:
- Central controller for the 32-point radix-2 single-path delay-feedback (SDF) FFT pipeline.
- Owns the global sample counter and drives one shared stage enable to every stage's delay line.
- Per stage, it drives the fill/butterfly mode select and the twiddle-ROM address.
- On the output side it produces output valid, output index (natural and bit-reversed) and frame-done. It also handles end-of-stream flush, i.e. draining the pipeline latency.

Parameters:
- LOGN, 5: log2 of FFT size; N = 2^LOGN. Supported 3..6.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present; accepted when in_valid && in_ready.
- flush  in  1  end-of-stream request; one-cycle pulse.
- in_ready  out  1  controller accepts samples (0 only in DRAIN).
- en  out  1  advance strobe to all stage registers and delay lines.
- stage_mode  out  LOGN  bit s: 1 = stage s in butterfly phase, 0 = fill/pass phase.
- tw_addr  out  LOGN*(LOGN-1)  field s = bits [s*(LOGN-1) +: LOGN-1]: twiddle index for stage s, in units of W_N.
- out_valid  out  1  pipeline output sample valid this cycle.
- out_idx  out  LOGN  output arrival position within frame, 0..N-1.
- out_bin  out  LOGN  bit-reverse(out_idx) = frequency bin of the output.
- frame_done  out  1  pulse with the last output of a frame.
- flush_err  out  1  pulse: flush rejected (not at a frame boundary).
- busy  out  1  state != IDLE.

Behaviour:
Per-stage constants:
- Delay length D_s = 2^(LOGN-1-s).
- Entry latency L_s = N - 2*D_s.
- Total pipeline latency is N-1 advances.

Registers:
- cnt: LOGN bits, wraps modulo N.
- tcnt: LOGN+1 bits, saturates at N.
- state: IDLE / RUN / DRAIN.
- dcnt: LOGN bits, drain counter.

State machine:
- IDLE:
  - in_ready=1; en = in_valid.
  - On in_valid: accept the sample, go to RUN.
- RUN:
  - in_ready=1; en = in_valid. in_valid low is a stall: all counters hold.
  - flush with cnt==0 after this cycle's advance: go to DRAIN with dcnt=0. A flush coincident with an accepted sample takes that sample first.
  - flush otherwise: flush_err=1 for one cycle, stay in RUN.
- DRAIN:
  - in_ready=0; en=1; in_valid is ignored. flush is ignored (no error pulse).
  - dcnt increments every cycle. After N-1 cycles go to IDLE and clear cnt, tcnt and dcnt to 0.

Counters:
- On every en: cnt <= cnt+1 mod N; tcnt <= min(tcnt+1, N).
- Outputs below are combinational from the current registers plus en. They describe the sample being advanced this cycle.

Mode and twiddle:
- stage_mode[s] = cnt[LOGN-1-s] && (tcnt >= L_s). It is forced 0 while stage s is unprimed.
- Twiddle field s: when tcnt == N (differences have reached the stage output) && stage_mode[s]==0, the value is cnt[LOGN-2-s:0] << s. Otherwise it is 0.
- The last stage field is therefore always 0.

Output side:
- out_valid = en && (tcnt >= N-1).
- out_idx = (cnt + 1) mod N; out_bin = bit-reverse(out_idx).
- frame_done = out_valid && out_idx == N-1.

Reset and drain:
- Reset values: state=IDLE; cnt, tcnt, dcnt = 0. Resulting outputs: en=0, out_valid=0, frame_done=0, flush_err=0, stage_mode=0, tw_addr=0, busy=0, in_ready=1.
- Reset mid-RUN or mid-DRAIN: abandon the frame immediately, no drain, outputs return to reset values next cycle.
- A DRAIN emits exactly N-1 out_valid cycles. The final one carries frame_done.

Test Plan:
1. Reset, then 32 back-to-back in_valid cycles:
   - stage_mode[0]=0 for cycles 0-15 and 1 for 16-31.
   - stage_mode[1] first goes high at cycle 24.
   - out_valid first asserts at cycle 31 with out_idx=0, out_bin=0.
   - tw_addr all 0 throughout.
2. Continue streaming a second frame:
   - At the cycles where cnt=0..15: tw field 0 = cnt, field 1 = (cnt&7)<<1 while stage_mode[1]=0.
   - frame_done at cnt=30, with out_idx=31, out_bin=31.
3. Insert a 5-cycle in_valid gap at cnt=10: en=0, and cnt, tcnt, stage_mode and tw_addr hold for all 5 cycles; out_valid=0.
4. Flush at cnt=17: flush_err pulses one cycle and state stays RUN. Then flush coincident with the sample taking cnt 31->0:
   - DRAIN for 31 cycles with in_ready=0; in_valid asserted during DRAIN is ignored.
   - 31 out_valid pulses, the last with frame_done.
   - Then IDLE, busy=0.
5. Assert rst mid-DRAIN (dcnt=12): the next cycle shows state=IDLE, cnt=0, tcnt=0, all outputs at reset values. A new stream then restarts with out_valid first at advance 31.
6. LOGN=3 build, 8 back-to-back samples: stage_mode[0] high at cycles 4-7; out_valid first at cycle 7; drain lasts 7 cycles.

Source files
------------

// File: rtl/fft_sdf_sequencer.sv
// Central controller for a radix-2 single-path delay-feedback FFT pipeline.
// Owns the sample counter, the shared advance strobe, per-stage butterfly
// mode and twiddle addresses, output indexing and end-of-stream draining.
module fft_sdf_sequencer #(
    parameter int LOGN = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       flush,
    output logic                       in_ready,
    output logic                       en,
    output logic [LOGN-1:0]            stage_mode,
    output logic [LOGN*(LOGN-1)-1:0]   tw_addr,
    output logic                       out_valid,
    output logic [LOGN-1:0]            out_idx,
    output logic [LOGN-1:0]            out_bin,
    output logic                       frame_done,
    output logic                       flush_err,
    output logic                       busy
);

    localparam int N  = 1 << LOGN;
    localparam int TW = LOGN - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] cnt_inc;
    logic [LOGN-1:0] dcnt;
    logic [LOGN:0]   tcnt;
    logic            drain_last;

    assign cnt_inc = cnt + 1'b1;

    // Next-state logic plus the handshake strobes; a flush is only honoured
    // when this cycle's advance (if any) leaves the counter at a frame boundary.
    always_comb begin
        state_next = state;
        en         = 1'b0;
        in_ready   = 1'b1;
        flush_err  = 1'b0;
        drain_last = 1'b0;
        case (state)
            IDLE: begin
                en = in_valid;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                en = in_valid;
                if (flush) begin
                    if ((in_valid ? cnt_inc : cnt) == '0) begin
                        state_next = DRAIN;
                    end else begin
                        flush_err = 1'b1;
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b0;
                en       = 1'b1;
                if (dcnt == LOGN'(N - 2)) begin
                    drain_last = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and counter registers; the last drain cycle returns everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tcnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            if (drain_last) begin
                cnt  <= '0;
                tcnt <= '0;
                dcnt <= '0;
            end else begin
                if (en) begin
                    cnt <= cnt_inc;
                    if (tcnt != (LOGN+1)'(N)) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                if (state == DRAIN) begin
                    dcnt <= dcnt + 1'b1;
                end else if (state_next == DRAIN) begin
                    dcnt <= '0;
                end
            end
        end
    end

    // Per-stage mode and twiddle: a stage only enters butterfly mode once its
    // delay line holds real data, and twiddles appear once the full frame depth
    // has passed so the difference terms are genuine.
    always_comb begin
        stage_mode = '0;
        tw_addr    = '0;
        for (int s = 0; s < LOGN; s++) begin
            stage_mode[s] = cnt[LOGN-1-s] && (int'(tcnt) >= (N - (N >> s)));
            if ((tcnt == (LOGN+1)'(N)) && !stage_mode[s]) begin
                tw_addr[s*TW +: TW] = TW'((cnt & LOGN'((1 << (LOGN - 1 - s)) - 1)) << s);
            end
        end
    end

    // Output bin is the bit-reversed arrival index of the advancing sample.
    always_comb begin
        out_bin = '0;
        for (int i = 0; i < LOGN; i++) begin
            out_bin[i] = out_idx[LOGN-1-i];
        end
    end

    assign out_valid  = en && (tcnt >= (LOGN+1)'(N - 1));
    assign out_idx    = cnt_inc;
    assign frame_done = out_valid && (out_idx == LOGN'(N - 1));
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_sdf_sequencer.sv
// Directed bench for the SDF FFT sequencer: a 32-point instance driven through
// streaming, stalls, flushes and reset-during-drain, plus an 8-point instance
// checked against a hand-computed vector table.
module tb_fft_sdf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-point instance
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, en, out_valid, frame_done, flush_err, busy;
    logic [4:0]  stage_mode, out_idx, out_bin;
    logic [19:0] tw_addr;

    // 8-point instance
    logic        rst3 = 1'b1;
    logic        iv3 = 1'b0;
    logic        fl3 = 1'b0;
    logic        rdy3, en3, ov3, fd3, ferr3, busy3;
    logic [2:0]  mode3, idx3, bin3;
    logic [5:0]  tw3;

    int checks = 0;
    int errors = 0;

    fft_sdf_sequencer #(.LOGN(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in_ready(in_ready), .en(en), .stage_mode(stage_mode), .tw_addr(tw_addr),
        .out_valid(out_valid), .out_idx(out_idx), .out_bin(out_bin),
        .frame_done(frame_done), .flush_err(flush_err), .busy(busy)
    );

    fft_sdf_sequencer #(.LOGN(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(iv3), .flush(fl3),
        .in_ready(rdy3), .en(en3), .stage_mode(mode3), .tw_addr(tw3),
        .out_valid(ov3), .out_idx(idx3), .out_bin(bin3),
        .frame_done(fd3), .flush_err(ferr3), .busy(busy3)
    );

    typedef struct {
        logic        iv;
        logic        fl;
        logic [20:0] exp;
    } vec3_t;

    vec3_t tbl[17];

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // During the first frame each stage primes in turn, so modes fill like a thermometer.
    function automatic logic [4:0] frame1Mode(input int k);
        return {k == 31, k >= 30, k >= 28, k >= 24, k >= 16};
    endfunction

    // Steady-state twiddle fields, written out per stage.
    function automatic logic [19:0] frame2Tw(input logic [4:0] k);
        logic [3:0] f0, f1, f2, f3;
        f0 = k[4] ? 4'd0 : k[3:0];
        f1 = k[3] ? 4'd0 : {k[2:0], 1'b0};
        f2 = k[2] ? 4'd0 : {k[1:0], 2'b00};
        f3 = k[1] ? 4'd0 : {k[0], 3'b000};
        return {4'd0, f3, f2, f1, f0};
    endfunction

    function automatic logic [40:0] expBig(input logic e, input logic r, input logic b,
                                           input logic [4:0] m, input logic [19:0] t,
                                           input logic ov, input logic [4:0] idx,
                                           input logic fd, input logic fe);
        return {e, r, b, m, t, ov, idx, rev5(idx), fd, fe};
    endfunction

    function automatic logic [20:0] mk3(input logic e, input logic r, input logic b,
                                        input logic [2:0] m, input logic [5:0] t,
                                        input logic ov, input logic [2:0] idx,
                                        input logic [2:0] bin, input logic fd,
                                        input logic fe);
        return {e, r, b, m, t, ov, idx, bin, fd, fe};
    endfunction

    task automatic applyStimulus(input logic r, input logic iv, input logic fl);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        flush    = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [40:0] exp);
        logic [40:0] got;
        got = {en, in_ready, busy, stage_mode, tw_addr, out_valid, out_idx, out_bin,
               frame_done, flush_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic checkSmall(input string name, input logic [20:0] exp);
        logic [20:0] got;
        got = {en3, rdy3, busy3, mode3, tw3, ov3, idx3, bin3, fd3, ferr3};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic runFrame1(input string tag, input logic flushAtEnd);
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, 1'b1, flushAtEnd && (k == 31));
            checkOutput($sformatf("%s k=%0d", tag, k),
                        expBig(1'b1, 1'b1, k != 0, frame1Mode(k), 20'd0, k == 31,
                               5'(k + 1), 1'b0, 1'b0));
        end
    endtask

    initial begin
        int ovCount;
        int fdCount;

        // 8-point table, hand-computed
        tbl[0]  = '{1'b0, 1'b0, mk3(0, 1, 0, 3'b000, 6'b000000, 0, 3'd1, 3'd4, 0, 0)};
        tbl[1]  = '{1'b1, 1'b0, mk3(1, 1, 0, 3'b000, 6'b000000, 0, 3'd1, 3'd4, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b000, 6'b000000, 0, 3'd2, 3'd2, 0, 0)};
        tbl[3]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b000, 6'b000000, 0, 3'd3, 3'd6, 0, 0)};
        tbl[4]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b000, 6'b000000, 0, 3'd4, 3'd1, 0, 0)};
        tbl[5]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b001, 6'b000000, 0, 3'd5, 3'd5, 0, 0)};
        tbl[6]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b001, 6'b000000, 0, 3'd6, 3'd3, 0, 0)};
        tbl[7]  = '{1'b1, 1'b0, mk3(1, 1, 1, 3'b011, 6'b000000, 0, 3'd7, 3'd7, 0, 0)};
        tbl[8]  = '{1'b1, 1'b1, mk3(1, 1, 1, 3'b111, 6'b000000, 1, 3'd0, 3'd0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b000, 6'b000000, 1, 3'd1, 3'd4, 0, 0)};
        tbl[10] = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b100, 6'b001001, 1, 3'd2, 3'd2, 0, 0)};
        tbl[11] = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b010, 6'b000010, 1, 3'd3, 3'd6, 0, 0)};
        tbl[12] = '{1'b1, 1'b1, mk3(1, 0, 1, 3'b110, 6'b000011, 1, 3'd4, 3'd1, 0, 0)};
        tbl[13] = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b001, 6'b000000, 1, 3'd5, 3'd5, 0, 0)};
        tbl[14] = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b101, 6'b001000, 1, 3'd6, 3'd3, 0, 0)};
        tbl[15] = '{1'b1, 1'b0, mk3(1, 0, 1, 3'b011, 6'b000000, 1, 3'd7, 3'd7, 1, 0)};
        tbl[16] = '{1'b0, 1'b0, mk3(0, 1, 0, 3'b000, 6'b000000, 0, 3'd1, 3'd4, 0, 0)};

        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset", expBig(1'b0, 1'b1, 1'b0, 5'd0, 20'd0, 1'b0, 5'd1, 1'b0, 1'b0));

        // First frame: stages prime one after another, no twiddles yet.
        runFrame1("frame1", 1'b0);

        // Second frame with a stall at cnt=10, a rejected flush at 17 and an
        // accepted flush on the wrap to 0.
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                for (int g = 0; g < 5; g++) begin
                    applyStimulus(1'b0, 1'b0, 1'b0);
                    checkOutput($sformatf("gap g=%0d", g),
                                expBig(1'b0, 1'b1, 1'b1, rev5(5'd10), frame2Tw(5'd10),
                                       1'b0, 5'd11, 1'b0, 1'b0));
                end
            end
            applyStimulus(1'b0, 1'b1, (k == 17) || (k == 31));
            checkOutput($sformatf("frame2 k=%0d", k),
                        expBig(1'b1, 1'b1, 1'b1, rev5(5'(k)), frame2Tw(5'(k)), 1'b1,
                               5'(k + 1), k == 30, k == 17));
        end

        // Drain: input and flush are ignored, 31 outputs, last one ends the frame.
        ovCount = 0;
        fdCount = 0;
        for (int j = 0; j < 31; j++) begin
            applyStimulus(1'b0, 1'b1, j == 7);
            checkOutput($sformatf("drain j=%0d", j),
                        expBig(1'b1, 1'b0, 1'b1, rev5(5'(j)), frame2Tw(5'(j)), 1'b1,
                               5'(j + 1), j == 30, 1'b0));
            ovCount += int'(out_valid);
            fdCount += int'(frame_done);
        end
        checkCount("drain out_valid count", ovCount, 31);
        checkCount("drain frame_done count", fdCount, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle after drain", expBig(1'b0, 1'b1, 1'b0, 5'd0, 20'd0, 1'b0, 5'd1, 1'b0, 1'b0));

        // Reset in the middle of a drain abandons the frame.
        runFrame1("frame1b", 1'b1);
        for (int j = 0; j <= 12; j++) begin
            applyStimulus(j == 12, 1'b0, 1'b0);
            checkOutput($sformatf("drain2 j=%0d", j),
                        expBig(1'b1, 1'b0, 1'b1, rev5(5'(j)), frame2Tw(5'(j)), 1'b1,
                               5'(j + 1), 1'b0, 1'b0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after mid-drain reset",
                    expBig(1'b0, 1'b1, 1'b0, 5'd0, 20'd0, 1'b0, 5'd1, 1'b0, 1'b0));
        runFrame1("restart", 1'b0);

        // 8-point instance from the table.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst3 = 1'b0;
            iv3  = tbl[i].iv;
            fl3  = tbl[i].fl;
            #1;
            checkSmall($sformatf("n8 vec=%0d", i), tbl[i].exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
